// File: rtl/writeback_unit_pkg.sv
// Shared Risky architecture constants plus the writeback arbitration source encoding.
// WB_QUEUE_DEPTH is the default load holding depth used by writeback_unit.
package writeback_unit_pkg;

    localparam int NUMBER_OF_GPRS = 32;
    localparam int DATA_SIZE      = 32;
    localparam int GPR_SIZE       = $clog2(NUMBER_OF_GPRS);
    localparam int WB_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_QUEUE,
        WB_SRC_LOAD
    } wb_source_e;

endpackage

// File: rtl/writeback_queue.sv
// In-order holding queue for load results that lost arbitration to an ALU write.
// Entries carry a valid bit so a younger ALU write can kill them in place without reordering.
module writeback_queue
    import writeback_unit_pkg::*;
#(
    parameter int DATA_SIZE = writeback_unit_pkg::DATA_SIZE,
    parameter int GPR_SIZE  = writeback_unit_pkg::GPR_SIZE,
    parameter int DEPTH     = writeback_unit_pkg::WB_QUEUE_DEPTH,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push,
    input  logic [GPR_SIZE-1:0]              push_address,
    input  logic [DATA_SIZE-1:0]             push_data,
    input  logic                             pop,
    input  logic                             kill_valid,
    input  logic [GPR_SIZE-1:0]              kill_address,
    output logic                             head_valid,
    output logic [GPR_SIZE-1:0]              head_address,
    output logic [DATA_SIZE-1:0]             head_data,
    output logic [CNT_W-1:0]                 count,
    output logic [PTR_W-1:0]                 head_pointer,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [DEPTH-1:0][GPR_SIZE-1:0]   entry_address,
    output logic [DEPTH-1:0][DATA_SIZE-1:0]  entry_data
);

    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][GPR_SIZE-1:0]  address_q, address_d;
    logic [DEPTH-1:0][DATA_SIZE-1:0] data_q, data_d;
    logic [PTR_W-1:0]                head_q, head_d;
    logic [PTR_W-1:0]                tail_q, tail_d;
    logic [CNT_W-1:0]                count_q, count_d;

    // Kill is applied before push so a same-cycle push is never cleared by it.
    always_comb begin
        valid_d   = valid_q;
        address_d = address_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (kill_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (address_q[i] == kill_address) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        if (push) begin
            valid_d[tail_q]   = 1'b1;
            address_d[tail_q] = push_address;
            data_d[tail_q]    = push_data;
            tail_d            = tail_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: it is only observed through its valid bit.
    always_ff @(posedge clock) begin
        address_q <= address_d;
        data_q    <= data_d;
    end

    assign head_valid    = valid_q[head_q];
    assign head_address  = address_q[head_q];
    assign head_data     = data_q[head_q];
    assign count         = count_q;
    assign head_pointer  = head_q;
    assign entry_valid   = valid_q;
    assign entry_address = address_q;
    assign entry_data    = data_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port driver merging ALU results and load responses, queueing colliding loads.
// Define WRITEBACK_BYPASS_EN to build the pending-value lookup for decode; otherwise query outputs are 0.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_SIZE   = writeback_unit_pkg::DATA_SIZE,
    parameter int GPR_SIZE    = writeback_unit_pkg::GPR_SIZE,
    parameter int QUEUE_DEPTH = writeback_unit_pkg::WB_QUEUE_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [GPR_SIZE-1:0]  alu_address,
    input  logic [DATA_SIZE-1:0] alu_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [GPR_SIZE-1:0]  load_address,
    input  logic [DATA_SIZE-1:0] load_data,
    output logic                 write_enable,
    output logic [GPR_SIZE-1:0]  write_address,
    output logic [DATA_SIZE-1:0] write_data,
    output logic                 pending,
    input  logic [GPR_SIZE-1:0]  query0_address,
    input  logic [GPR_SIZE-1:0]  query1_address,
    output logic                 query0_hit,
    output logic                 query1_hit,
    output logic [DATA_SIZE-1:0] query0_data,
    output logic [DATA_SIZE-1:0] query1_data
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                                  alu_write;
    logic                                  load_take;
    logic                                  load_ready_int;
    logic                                  queue_push;
    logic                                  queue_pop;
    wb_source_e                            source;

    logic                                  head_valid;
    logic [GPR_SIZE-1:0]                   head_address;
    logic [DATA_SIZE-1:0]                  head_data;
    logic [CNT_W-1:0]                      queue_count;
    logic [PTR_W-1:0]                      queue_head;
    logic [QUEUE_DEPTH-1:0]                entry_valid;
    logic [QUEUE_DEPTH-1:0][GPR_SIZE-1:0]  entry_address;
    logic [QUEUE_DEPTH-1:0][DATA_SIZE-1:0] entry_data;

    logic                                  write_enable_q, write_enable_d;
    logic [GPR_SIZE-1:0]                   write_address_q, write_address_d;
    logic [DATA_SIZE-1:0]                  write_data_q, write_data_d;

    assign load_ready_int = !reset && (queue_count < CNT_W'(QUEUE_DEPTH));

    // A same-cycle load to the ALU's register is older than the ALU result, so it is dropped.
    always_comb begin
        alu_write  = alu_valid && (alu_address != '0);
        load_take  = load_valid && load_ready_int && (load_address != '0)
                     && !(alu_write && (load_address == alu_address));
        source     = WB_SRC_NONE;
        queue_push = 1'b0;
        queue_pop  = 1'b0;

        if (alu_write) begin
            source     = WB_SRC_ALU;
            queue_push = load_take;
        end else if (queue_count != '0) begin
            source     = WB_SRC_QUEUE;
            queue_pop  = 1'b1;
            queue_push = load_take;
        end else if (load_take) begin
            source     = WB_SRC_LOAD;
        end
    end

    always_comb begin
        write_enable_d  = 1'b0;
        write_address_d = '0;
        write_data_d    = '0;

        case (source)
            WB_SRC_ALU: begin
                write_enable_d  = 1'b1;
                write_address_d = alu_address;
                write_data_d    = alu_data;
            end
            WB_SRC_QUEUE: begin
                if (head_valid) begin
                    write_enable_d  = 1'b1;
                    write_address_d = head_address;
                    write_data_d    = head_data;
                end
            end
            WB_SRC_LOAD: begin
                write_enable_d  = 1'b1;
                write_address_d = load_address;
                write_data_d    = load_data;
            end
            default: begin
                write_enable_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    writeback_queue #(
        .DATA_SIZE (DATA_SIZE),
        .GPR_SIZE  (GPR_SIZE),
        .DEPTH     (QUEUE_DEPTH)
    ) u_queue (
        .clock         (clock),
        .reset         (reset),
        .push          (queue_push),
        .push_address  (load_address),
        .push_data     (load_data),
        .pop           (queue_pop),
        .kill_valid    (alu_write),
        .kill_address  (alu_address),
        .head_valid    (head_valid),
        .head_address  (head_address),
        .head_data     (head_data),
        .count         (queue_count),
        .head_pointer  (queue_head),
        .entry_valid   (entry_valid),
        .entry_address (entry_address),
        .entry_data    (entry_data)
    );

    assign load_ready    = load_ready_int;
    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign pending       = (queue_count != '0) || write_enable_q;

`ifdef WRITEBACK_BYPASS_EN
    // Queue scanned oldest to youngest so later matches overwrite; the write stage has final say.
    function automatic logic [DATA_SIZE:0] lookup(
        input logic [GPR_SIZE-1:0]                   query,
        input logic                                  stage_valid,
        input logic [GPR_SIZE-1:0]                   stage_address,
        input logic [DATA_SIZE-1:0]                  stage_data,
        input logic [PTR_W-1:0]                      head,
        input logic [QUEUE_DEPTH-1:0]                valid,
        input logic [QUEUE_DEPTH-1:0][GPR_SIZE-1:0]  address,
        input logic [QUEUE_DEPTH-1:0][DATA_SIZE-1:0] data
    );
        logic                 hit;
        logic [DATA_SIZE-1:0] value;
        logic [PTR_W-1:0]     index;
        hit   = 1'b0;
        value = '0;
        if (query != '0) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                index = head + PTR_W'(i);
                if (valid[index] && (address[index] == query)) begin
                    hit   = 1'b1;
                    value = data[index];
                end
            end
            if (stage_valid && (stage_address == query)) begin
                hit   = 1'b1;
                value = stage_data;
            end
        end
        return {hit, value};
    endfunction

    always_comb begin
        {query0_hit, query0_data} = lookup(query0_address, write_enable_q, write_address_q,
                                           write_data_q, queue_head, entry_valid,
                                           entry_address, entry_data);
        {query1_hit, query1_data} = lookup(query1_address, write_enable_q, write_address_q,
                                           write_data_q, queue_head, entry_valid,
                                           entry_address, entry_data);
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{query0_address, query1_address, queue_head,
                             entry_valid, entry_address, entry_data};
    assign query0_hit  = 1'b0;
    assign query1_hit  = 1'b0;
    assign query0_data = '0;
    assign query1_data = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, bypass sequence, then random traffic
// compared against a queue-based reference model.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int DW = DATA_SIZE;
    localparam int GW = GPR_SIZE;
    localparam int QD = WB_QUEUE_DEPTH;

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [GW-1:0] alu_address;
    logic [DW-1:0] alu_data;
    logic          load_valid;
    logic          load_ready;
    logic [GW-1:0] load_address;
    logic [DW-1:0] load_data;
    logic          write_enable;
    logic [GW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          pending;
    logic [GW-1:0] query0_address;
    logic [GW-1:0] query1_address;
    logic          query0_hit;
    logic          query1_hit;
    logic [DW-1:0] query0_data;
    logic [DW-1:0] query1_data;

    always #5 clock = ~clock;

    writeback_unit #(
        .DATA_SIZE   (DW),
        .GPR_SIZE    (GW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_address    (alu_address),
        .alu_data       (alu_data),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_address   (load_address),
        .load_data      (load_data),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .pending        (pending),
        .query0_address (query0_address),
        .query1_address (query1_address),
        .query0_hit     (query0_hit),
        .query1_hit     (query1_hit),
        .query0_data    (query0_data),
        .query1_data    (query1_data)
    );

    typedef struct {
        logic          rst;
        logic          alu_v;
        logic [GW-1:0] alu_a;
        logic [DW-1:0] alu_d;
        logic          load_v;
        logic [GW-1:0] load_a;
        logic [DW-1:0] load_d;
        logic          exp_we;
        logic [GW-1:0] exp_wa;
        logic [DW-1:0] exp_wd;
        logic          exp_ready;
        logic          exp_pending;
    } vec_t;

    typedef struct {
        logic [GW-1:0] addr;
        logic [DW-1:0] data;
        bit            live;
    } entry_t;

    vec_t          vecs[$];
    entry_t        mq[$];
    bit            m_we;
    logic [GW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            nVectors     = 0;
    int            nMiscompares = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic av, input logic [GW-1:0] aa,
                                 input logic [DW-1:0] ad, input logic lv, input logic [GW-1:0] la,
                                 input logic [DW-1:0] ld, input logic [GW-1:0] q0,
                                 input logic [GW-1:0] q1);
        reset          = rst;
        alu_valid      = av;
        alu_address    = aa;
        alu_data       = ad;
        load_valid     = lv;
        load_address   = la;
        load_data      = ld;
        query0_address = q0;
        query1_address = q1;
    endtask

    function automatic void addVec(input logic rst, input logic av, input int aa, input int ad,
                                   input logic lv, input int la, input int ld, input logic we,
                                   input int wa, input int wd, input logic rdy, input logic pnd);
        vec_t v;
        v.rst = rst;   v.alu_v = av;  v.alu_a = GW'(aa);  v.alu_d = DW'(ad);
        v.load_v = lv; v.load_a = GW'(la); v.load_d = DW'(ld);
        v.exp_we = we; v.exp_wa = GW'(wa); v.exp_wd = DW'(wd);
        v.exp_ready = rdy; v.exp_pending = pnd;
        vecs.push_back(v);
    endfunction

    // Reference model: advances the expected state across one rising edge.
    task automatic modelStep(input bit rst, input bit av, input logic [GW-1:0] aa,
                             input logic [DW-1:0] ad, input bit lv, input logic [GW-1:0] la,
                             input logic [DW-1:0] ld);
        bit     aluWrites;
        bit     loadLive;
        entry_t e;
        if (rst) begin
            mq.delete();
            m_we = 0; m_wa = '0; m_wd = '0;
        end else begin
            aluWrites = av && (aa != 0);
            loadLive  = lv && (mq.size() < QD) && (la != 0) && !(aluWrites && la == aa);
            e.addr = la; e.data = ld; e.live = 1;
            if (aluWrites) begin
                foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 0;
                m_we = 1; m_wa = aa; m_wd = ad;
                if (loadLive) mq.push_back(e);
            end else if (mq.size() > 0) begin
                entry_t h;
                h = mq.pop_front();
                m_we = h.live; m_wa = h.addr; m_wd = h.data;
                if (loadLive) mq.push_back(e);
            end else if (loadLive) begin
                m_we = 1; m_wa = la; m_wd = ld;
            end else begin
                m_we = 0;
            end
        end
    endtask

    function automatic void modelQuery(input logic [GW-1:0] q, output bit hit,
                                       output logic [DW-1:0] d);
        hit = 0;
        d   = '0;
`ifdef WRITEBACK_BYPASS_EN
        if (q != 0) begin
            if (m_we && m_wa == q) begin
                hit = 1; d = m_wd;
            end else begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (mq[i].live && mq[i].addr == q) begin
                        hit = 1; d = mq[i].data;
                        break;
                    end
                end
            end
        end
`else
        if (q == '1) hit = 0;
`endif
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit            expHit;
        logic [DW-1:0] expData;
        bit            bypassOn;
`ifdef WRITEBACK_BYPASS_EN
        bypassOn = 1;
`else
        bypassOn = 0;
`endif

        //     rst av aa  ad      lv la ld       we wa wd      rdy pnd
        addVec(1, 0, 0,  0,      1, 9, 'h99,    0, 0, 0,      0, 0);
        addVec(1, 0, 0,  0,      1, 9, 'h99,    0, 0, 0,      0, 0);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 1, 5,  'h11,   1, 6, 'h22,    1, 5, 'h11,   1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       1, 6, 'h22,   1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 1, 10, 'h100,  1, 1, 'h1001,  1, 10, 'h100, 1, 1);
        addVec(0, 1, 11, 'h101,  1, 2, 'h1002,  1, 11, 'h101, 1, 1);
        addVec(0, 1, 12, 'h102,  1, 3, 'h1003,  1, 12, 'h102, 1, 1);
        addVec(0, 1, 13, 'h103,  1, 4, 'h1004,  1, 13, 'h103, 0, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       1, 1, 'h1001, 1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       1, 2, 'h1002, 1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       1, 3, 'h1003, 1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       1, 4, 'h1004, 1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 1, 8,  'h55,   1, 7, 'hAA,    1, 8, 'h55,   1, 1);
        addVec(0, 1, 7,  'hBB,   0, 0, 0,       1, 7, 'hBB,   1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 1, 0,  'hFF,   1, 0, 'hEE,    0, 0, 0,      1, 0);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 1, 9,  'h77,   1, 9, 'h66,    1, 9, 'h77,   1, 1);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);
        addVec(0, 1, 10, 'h200,  1, 1, 'h5,     1, 10, 'h200, 1, 1);
        addVec(0, 1, 11, 'h201,  1, 2, 'h6,     1, 11, 'h201, 1, 1);
        addVec(1, 0, 0,  0,      0, 0, 0,       0, 0, 0,      0, 0);
        addVec(0, 0, 0,  0,      0, 0, 0,       0, 0, 0,      1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d,
                          vecs[i].load_v, vecs[i].load_a, vecs[i].load_d, '0, '0);
            @(posedge clock); #1;
            checkOutput($sformatf("vec%0d write_enable", i), DW'(write_enable), DW'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                checkOutput($sformatf("vec%0d write_address", i), DW'(write_address), DW'(vecs[i].exp_wa));
                checkOutput($sformatf("vec%0d write_data", i), write_data, vecs[i].exp_wd);
            end
            checkOutput($sformatf("vec%0d load_ready", i), DW'(load_ready), DW'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d pending", i), DW'(pending), DW'(vecs[i].exp_pending));
        end

        // Two queued loads to x3: the younger one must be the bypass answer.
        applyStimulus(0, 1, 20, 'h20, 1, 3, 'h1, 3, 0);
        @(posedge clock); #1;
        applyStimulus(0, 1, 21, 'h21, 1, 3, 'h2, 3, 0);
        @(posedge clock); #1;
        checkOutput("bypass q0 hit", DW'(query0_hit), DW'(bypassOn));
        checkOutput("bypass q0 data", query0_data, bypassOn ? DW'(2) : DW'(0));
        checkOutput("bypass q1 hit", DW'(query1_hit), DW'(0));
        checkOutput("bypass q1 data", query1_data, DW'(0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        checkOutput("drain1 write_enable", DW'(write_enable), DW'(1));
        checkOutput("drain1 write_data", write_data, DW'(1));
        @(posedge clock); #1;
        checkOutput("drain2 write_enable", DW'(write_enable), DW'(1));
        checkOutput("drain2 write_data", write_data, DW'(2));
        @(posedge clock); #1;
        checkOutput("drain3 write_enable", DW'(write_enable), DW'(0));

        for (int c = 0; c < 800; c++) begin
            bit            rst;
            bit            av;
            bit            lv;
            logic [GW-1:0] aa;
            logic [GW-1:0] la;
            logic [GW-1:0] q0;
            logic [GW-1:0] q1;
            logic [DW-1:0] ad;
            logic [DW-1:0] ld;
            rst = (c == 0) || ($urandom_range(0, 59) == 0);
            av  = ($urandom_range(0, 99) < 60);
            lv  = ($urandom_range(0, 99) < 70);
            aa  = GW'($urandom_range(0, 7));
            la  = GW'($urandom_range(0, 7));
            q0  = GW'($urandom_range(0, 7));
            q1  = GW'($urandom_range(0, 7));
            ad  = DW'($urandom);
            ld  = DW'($urandom);
            applyStimulus(rst, av, aa, ad, lv, la, ld, q0, q1);
            modelStep(rst, av, aa, ad, lv, la, ld);
            @(posedge clock); #1;
            checkOutput($sformatf("rand%0d write_enable", c), DW'(write_enable), DW'(m_we));
            if (m_we) begin
                checkOutput($sformatf("rand%0d write_address", c), DW'(write_address), DW'(m_wa));
                checkOutput($sformatf("rand%0d write_data", c), write_data, m_wd);
            end
            checkOutput($sformatf("rand%0d load_ready", c), DW'(load_ready),
                        DW'(!rst && (mq.size() < QD)));
            checkOutput($sformatf("rand%0d pending", c), DW'(pending),
                        DW'((mq.size() != 0) || m_we));
            modelQuery(q0, expHit, expData);
            checkOutput($sformatf("rand%0d query0_hit", c), DW'(query0_hit), DW'(expHit));
            checkOutput($sformatf("rand%0d query0_data", c), query0_data, expData);
            modelQuery(q1, expHit, expData);
            checkOutput($sformatf("rand%0d query1_hit", c), DW'(query1_hit), DW'(expHit));
            checkOutput($sformatf("rand%0d query1_data", c), query1_data, expData);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
